bpm_tick_gen: RTL and testbench
===============================

Name: bpm_tick_gen

Overview:
- Parametrised tempo generator; successor to the single-output bpm enable block.
- Converts a runtime BPM value into cycle-exact subdivision, beat and measure enable ticks for the sequencer and note players.
- Uses an iterative (multi-cycle) divider with a load/ready handshake, so no combinational divider is built.
- Supports pause/resume, phase restart and a programmable beats-per-measure count.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- CNT_W, 32, period counter and divider width; CLK_HZ*60 must fit in CNT_W bits.
- BPM_W, 9, width of the bpm input.
- SUBDIV, 2, subdivision ticks per beat; must be >= 1.
- BEATS_W, 3, width of beats_per_measure and beat_idx.
- DEFAULT_BPM, 120, tempo applied at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- load_bpm  in  1  request to load bpm and beats_per_measure; honoured only when ready=1.
- bpm  in  BPM_W  requested tempo in beats per minute.
- beats_per_measure  in  BEATS_W  beats per measure; 0 is treated as 1.
- play  in  1  level; 1 = run, 0 = pause (counter holds).
- restart  in  1  synchronous phase restart pulse.
- ready  out  1  divider idle; load accepted.
- bpm_err  out  1  one-cycle pulse when a load with bpm==0 is rejected.
- tick_sub  out  1  one-cycle subdivision tick.
- tick_beat  out  1  one-cycle tick on the first subdivision of each beat.
- tick_measure  out  1  one-cycle tick on the first subdivision of each measure.
- sub_idx  out  $clog2(SUBDIV) (min 1)  subdivision index of the most recent tick.
- beat_idx  out  BEATS_W  beat index of the most recent tick.
- period  out  CNT_W  active cycles per subdivision (P).

Behaviour:
- Reset (asynchronous, reset=0):
  - period = max(2, CLK_HZ*60/(DEFAULT_BPM*SUBDIV)), computed as an elaboration-time constant.
  - Counter loaded with period-1; pending register cleared.
  - bpm_err=0; all ticks 0; sub_idx=0; beat_idx=0; beats-per-measure register = 4.
  - ready = 1 on the first cycle after reset releases.
- Period: P = floor(CLK_HZ*60 / (bpm*SUBDIV)), clamped to a minimum of 2. The product bpm*SUBDIV is formed at CNT_W width.
- Load handshake:
  - load_bpm=1 and ready=1 with bpm!=0: latch the operands and beats_per_measure (0 becomes 1), then start the restoring divider, one quotient bit per cycle.
  - ready=0 starting the cycle after acceptance; ready=1 again exactly CNT_W+1 cycles after the accepting edge.
  - bpm==0: no divide starts, ready stays 1, and bpm_err pulses for 1 cycle.
  - load_bpm while ready=0 is ignored with no error.
- Adoption (glitch-free):
  - The divider result goes to a pending register.
  - The old period keeps running until the next counter wrap, where the counter reloads with new P-1 and period updates.
  - A restart that coincides with or follows completion adopts the new P immediately.
  - beats_per_measure takes effect at the next measure boundary.
- Counter:
  - Counts down only while play=1; holds its value while play=0.
  - At count==0 with play=1: reload with P-1 and register a tick, so tick_sub is high for 1 cycle the following cycle.
  - Consecutive ticks are exactly P cycles apart while play stays high.
- Tick qualification:
  - tick_beat = tick_sub when the tick's sub_idx==0.
  - tick_measure = tick_beat when the tick's beat_idx==0.
  - sub_idx and beat_idx show the values belonging to the current tick.
  - sub_idx wraps at SUBDIV-1 and increments beat_idx; beat_idx wraps at beats_per_measure-1.
  - First tick after reset or restart is a measure downbeat: sub_idx=0, beat_idx=0, all three ticks high.
- restart=1:
  - Counter reloads with P-1, indices return to the pre-first-tick state, and any registered tick is cleared.
  - Takes priority over counting.
  - Does not abort an in-flight divide.
- play low does not clear the indices. Ticks are never emitted while play=0.
- Reset mid-divide: abort the divide, discard the pending result, and restore default values.

Test Plan:
- CLK_HZ=1000, SUBDIV=2, reset, play=1 -> period=250; first tick_sub/tick_beat/tick_measure 250 cycles after release; tick_sub every 250 cycles; tick_beat every 500 cycles; tick_measure every 2000 cycles (4 beats).
- load_bpm with bpm=60 -> ready low for CNT_W+1 cycles; period becomes 500 at the next wrap, not earlier; the tick interval goes 250, then 500.
- load_bpm with bpm=0 -> bpm_err high 1 cycle, ready stays 1, period unchanged at 250.
- Second load_bpm during a busy divide -> ignored; the final period reflects the first request only.
- play low for 100 cycles mid-period -> no ticks; the next tick arrives 100 cycles late with the remaining count preserved.
- beats_per_measure=3 loaded, then restart -> immediate downbeat phase; tick_measure every 3 beats thereafter; beats_per_measure=0 yields tick_measure on every beat.

Source files
------------

// File: rtl/bpm_tick_gen.sv
// bpm_tick_gen: tempo generator producing subdivision, beat and measure ticks from a runtime BPM.
//   clk/reset(async, active-low); load_bpm/bpm/beats_per_measure -> ready/bpm_err handshake;
//   play (run/pause), restart (phase reset); tick_sub/tick_beat/tick_measure, sub_idx, beat_idx, period.
module bpm_tick_gen #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int BPM_W       = 9,
  parameter int SUBDIV      = 2,
  parameter int BEATS_W     = 3,
  parameter int DEFAULT_BPM = 120,
  localparam int SUB_W      = (SUBDIV > 1) ? $clog2(SUBDIV) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_bpm,
  input  logic [BPM_W-1:0]   bpm,
  input  logic [BEATS_W-1:0] beats_per_measure,
  input  logic               play,
  input  logic               restart,
  output logic               ready,
  output logic               bpm_err,
  output logic               tick_sub,
  output logic               tick_beat,
  output logic               tick_measure,
  output logic [SUB_W-1:0]   sub_idx,
  output logic [BEATS_W-1:0] beat_idx,
  output logic [CNT_W-1:0]   period
);
  localparam int STEP_W = $clog2(CNT_W + 1);
  localparam logic [63:0] NUM64 = 64'(CLK_HZ) * 64'd60;
  localparam logic [CNT_W-1:0] NUM = CNT_W'(NUM64);
  localparam logic [63:0] DEF_Q = NUM64 / (64'(DEFAULT_BPM) * 64'(SUBDIV));
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'((DEF_Q < 64'd2) ? 64'd2 : DEF_Q);
  logic               busy, done, ge, accept;
  logic [STEP_W-1:0]  step;
  logic [CNT_W-1:0]   rem, quo, den, diff, q_fix, pend, new_p, p_use, cnt;
  logic [CNT_W:0]     trial;
  logic               pend_v, avail, wrap, reload, adopt, tick_r, armed;
  logic [BEATS_W-1:0] beats, beats_pend, beat_nxt;
  logic [SUB_W-1:0]   sub_nxt;
  logic               sub_last, beat_last;
  // Restoring division step; the remainder stays below den, so the low CNT_W bits of the difference suffice.
  always_comb begin
    accept    = load_bpm && !busy && bpm != '0;
    done      = busy && step == '0;
    trial     = {rem, quo[CNT_W-1]};
    ge        = trial >= {1'b0, den};
    diff      = trial[CNT_W-1:0] - den;
    q_fix     = (quo < CNT_W'(2)) ? CNT_W'(2) : quo;
    avail     = done || pend_v;
    new_p     = done ? q_fix : pend;
    wrap      = play && cnt == '0;
    reload    = restart || wrap;
    adopt     = reload && avail;
    p_use     = adopt ? new_p : period;
    sub_last  = sub_idx == SUB_W'(SUBDIV - 1);
    beat_last = beat_idx == beats - 1'b1;
    sub_nxt   = sub_last ? '0 : sub_idx + 1'b1;
    beat_nxt  = sub_last ? (beat_last ? '0 : beat_idx + 1'b1) : beat_idx;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      step       <= '0;
      rem        <= '0;
      quo        <= '0;
      den        <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      period     <= DEF_P;
      cnt        <= DEF_P - 1'b1;
      tick_r     <= 1'b0;
      bpm_err    <= 1'b0;
      sub_idx    <= '0;
      beat_idx   <= '0;
      armed      <= 1'b1;
      beats      <= BEATS_W'(4);
      beats_pend <= BEATS_W'(4);
    end else begin
      bpm_err <= load_bpm && !busy && bpm == '0;
      if (accept) begin
        busy       <= 1'b1;
        step       <= STEP_W'(CNT_W);
        rem        <= '0;
        quo        <= NUM;
        den        <= CNT_W'(bpm) * CNT_W'(SUBDIV);
        beats_pend <= (beats_per_measure == '0) ? BEATS_W'(1) : beats_per_measure;
      end else if (done) begin
        busy <= 1'b0;
      end else if (busy) begin
        rem  <= ge ? diff : trial[CNT_W-1:0];
        quo  <= {quo[CNT_W-2:0], ge};
        step <= step - 1'b1;
      end
      if (done) pend <= q_fix;
      pend_v <= !adopt && avail;
      if (reload) begin
        cnt    <= p_use - 1'b1;
        period <= p_use;
      end else if (play) begin
        cnt <= cnt - 1'b1;
      end
      tick_r <= !restart && wrap;
      // A downbeat (first tick after reset/restart, or a measure wrap) is where a new beats count takes over.
      if (restart) begin
        sub_idx  <= '0;
        beat_idx <= '0;
        armed    <= 1'b1;
      end else if (wrap) begin
        sub_idx  <= armed ? '0 : sub_nxt;
        beat_idx <= armed ? '0 : beat_nxt;
        armed    <= 1'b0;
        if (armed || (sub_last && beat_last)) beats <= beats_pend;
      end
    end
  end
  assign ready        = !busy;
  assign tick_sub     = tick_r && play;
  assign tick_beat    = tick_sub && sub_idx == '0;
  assign tick_measure = tick_beat && beat_idx == '0;
endmodule

// File: tb/tb_bpm_tick_gen.sv
// tb_bpm_tick_gen: directed self-checking bench for bpm_tick_gen at CLK_HZ=1000, SUBDIV=2.
module tb_bpm_tick_gen;
  logic        clk = 1'b0, reset = 1'b0, load_bpm = 1'b0, play = 1'b1, restart = 1'b0;
  logic [8:0]  bpm = '0;
  logic [2:0]  beats_per_measure = 3'd4;
  logic        ready, bpm_err, tick_sub, tick_beat, tick_measure;
  logic [0:0]  sub_idx;
  logic [2:0]  beat_idx;
  logic [31:0] period;
  int          cyc = 0, checks = 0, errors = 0;
  bpm_tick_gen #(.CLK_HZ(1000)) dut (
    .clk(clk), .reset(reset), .load_bpm(load_bpm), .bpm(bpm),
    .beats_per_measure(beats_per_measure), .play(play), .restart(restart),
    .ready(ready), .bpm_err(bpm_err), .tick_sub(tick_sub), .tick_beat(tick_beat),
    .tick_measure(tick_measure), .sub_idx(sub_idx), .beat_idx(beat_idx), .period(period)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic next_tick(output int t);
    int n = 0;
    do begin @(negedge clk); n++; end while (!tick_sub && n < 5000);
    if (!tick_sub) check("tick_timeout", 0, 1);
    t = cyc;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) check("ready_timeout", 0, 1);
  endtask
  task automatic load(input int b, input int bpmv);
    bpm = 9'(bpmv);
    beats_per_measure = 3'(b);
    load_bpm = 1'b1;
    @(negedge clk);
    load_bpm = 1'b0;
  endtask
  initial begin
    int tr, tp, t, n, hits;
    repeat (3) @(negedge clk);
    check("rst_period", period, 250);
    check("rst_ready", ready, 1);
    check("rst_tick", {tick_sub, tick_beat, tick_measure}, 0);
    check("rst_idx", {sub_idx, beat_idx}, 0);
    check("rst_err", bpm_err, 0);
    reset = 1'b1;
    tr = cyc;
    next_tick(t);
    check("first_dt", t - tr, 250);
    check("first_ticks", {tick_beat, tick_measure}, 2'b11);
    check("first_idx", {sub_idx, beat_idx}, 0);
    tp = t;
    for (int i = 0; i < 8; i++) begin
      next_tick(t);
      check("sub_dt", t - tp, 250);
      check("beat_q", tick_beat, 1'(i % 2 == 1));
      check("measure_q", tick_measure, 1'(i == 7));
      tp = t;
    end
    load(4, 0);
    check("err_pulse", bpm_err, 1);
    check("err_ready", ready, 1);
    @(negedge clk);
    check("err_clear", bpm_err, 0);
    check("err_period", period, 250);
    load(4, 60);
    check("busy", ready, 0);
    n = 0;
    bpm = 9'd90;
    load_bpm = 1'b1;
    repeat (2) begin @(negedge clk); n++; end
    load_bpm = 1'b0;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    check("busy_len", n, 33);
    check("period_held", period, 250);
    next_tick(t);
    check("old_interval", t - tp, 250);
    check("adopted", period, 500);
    tp = t;
    next_tick(t);
    check("new_interval", t - tp, 500);
    tp = t;
    repeat (100) @(negedge clk);
    play = 1'b0;
    hits = 0;
    repeat (100) begin @(negedge clk); hits += int'(tick_sub); end
    play = 1'b1;
    check("pause_ticks", hits, 0);
    next_tick(t);
    check("pause_interval", t - tp, 600);
    check("pause_idx", {sub_idx, beat_idx}, {1'b1, 3'd1});
    load(3, 90);
    wait_ready(n);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    tr = cyc;
    check("restart_period", period, 333);
    next_tick(t);
    check("restart_dt", t - tr, 333);
    check("restart_down", {tick_beat, tick_measure}, 2'b11);
    tp = t;
    for (int i = 0; i < 6; i++) begin
      next_tick(t);
      check("b3_dt", t - tp, 333);
      check("b3_measure", tick_measure, 1'(i == 5));
      tp = t;
    end
    load(0, 90);
    wait_ready(n);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    next_tick(t);
    check("b0_down", tick_measure, 1);
    for (int i = 0; i < 4; i++) begin
      next_tick(t);
      check("b0_measure", tick_measure, 1'(i % 2 == 1));
      check("b0_beat_idx", beat_idx, 0);
    end
    load(4, 60);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_period", period, 250);
    check("mid_rst_ready", ready, 1);
    reset = 1'b1;
    tr = cyc;
    next_tick(t);
    check("mid_rst_dt", t - tr, 250);
    check("mid_rst_keep", period, 250);
    tp = t;
    next_tick(t);
    check("mid_rst_dt2", t - tp, 250);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
